// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle, WIDTH+2 cycle latency).
//
// Ports:
//   clk        - clock
//   reset      - synchronous, active-high reset
//   start      - request pulse, accepted only while busy=0
//   op         - RV32M funct3 (0 MUL .. 7 REMU)
//   operand_1  - rs1 (multiplicand / dividend)
//   operand_2  - rs2 (multiplier / divisor)
//   busy       - operation in progress (CALC or FIX)
//   done       - one-cycle pulse, result valid
//   result     - registered result, held until the next completion
//
// Optional feature: define MUL_DIV_EARLY_OUT_EN to send divide-by-zero and
// signed-overflow divides straight to FIX (done at t+2 instead of t+WIDTH+2).

module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // |operand_1|
    logic [WIDTH-1:0]   b_q, b_d;          // |operand_2|
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;      // product, or {unused, dividend->quotient}
    logic [WIDTH:0]     rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Start-cycle operand decode
    logic               signed1_c, signed2_c, neg1_c, neg2_c, early_c;
    logic [WIDTH-1:0]   mag1_c, mag2_c;

    always_comb begin
        signed1_c = op[2] ? ~op[0] : (op != 3'd3);
        signed2_c = op[2] ? ~op[0] : ~op[1];
        neg1_c    = signed1_c & operand_1[WIDTH-1];
        neg2_c    = signed2_c & operand_2[WIDTH-1];
        mag1_c    = neg1_c ? -operand_1 : operand_1;
        mag2_c    = neg2_c ? -operand_2 : operand_2;
`ifdef MUL_DIV_EARLY_OUT_EN
        early_c   = op[2] && ((operand_2 == '0) ||
                    (~op[0] && operand_1 == {1'b1, {(WIDTH-1){1'b0}}} && operand_2 == '1));
`else
        early_c   = 1'b0;
`endif
    end

    // One iteration of shift-add multiply and restoring divide
    logic [WIDTH:0]     mul_sum_c;
    logic [ACC_W-1:0]   mul_next_c;
    logic [WIDTH+1:0]   rem_shift_c, div_diff_c;
    logic               div_ok_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
        rem_shift_c = {rem_q, acc_q[WIDTH-1]};
        div_diff_c  = rem_shift_c - {2'b00, b_q};
        div_ok_c    = ~div_diff_c[WIDTH+1];
    end

    // Sign correction and result selection for FIX
    logic [ACC_W-1:0]   prod_c;
    logic [WIDTH-1:0]   quot_c, remv_c, op1_c, fix_c;
    logic               b_zero_c;

    always_comb begin
        prod_c   = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        quot_c   = (sign1_q ^ sign2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        remv_c   = sign1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        op1_c    = sign1_q ? -a_q : a_q;
        b_zero_c = (b_q == '0);
        case (op_q)
            3'd0:       fix_c = prod_c[WIDTH-1:0];
            3'd1,
            3'd2,
            3'd3:       fix_c = prod_c[ACC_W-1:WIDTH];
            3'd4,
            3'd5:       fix_c = b_zero_c ? '1 : quot_c;
            default:    fix_c = b_zero_c ? op1_c : remv_c;
        endcase
    end

    // Next-state and register-input logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = mag1_c;
                    b_d     = mag2_c;
                    sign1_d = neg1_c;
                    sign2_d = neg2_c;
                    cnt_d   = CNT_W'(WIDTH);
                    // Multiply shifts the multiplier out; divide shifts the dividend out.
                    acc_d   = {{WIDTH{1'b0}}, (op[2] ? mag1_c : mag2_c)};
                    rem_d   = '0;
                    state_d = early_c ? S_FIX : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-2:0], div_ok_c};
                    rem_d = div_ok_c ? div_diff_c[WIDTH:0] : rem_shift_c[WIDTH:0];
                end else begin
                    acc_d = mul_next_c;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_c;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
